cnn_layer_accel_sys_mem_rd_arb: RTL and testbench

CNN_LAYER_ACCEL_SYS_MEM_RD_ARB -- requirements
Module: cnn_layer_accel_sys_mem_rd_arb

---
 rtl/cnn_layer_accel_sys_mem_rd_arb.sv | 182 ++++++++++++++++++
 tb/tb_cnn_layer_accel_sys_mem_rd_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_sys_mem_rd_arb.sv
// Round-robin arbiter that serialises per-ID system-memory read requests onto
// a single AXI read-master command/data channel, one transfer at a time.

`ifndef MAX_FAS_RD_ID
`define MAX_FAS_RD_ID 4
`endif
`ifndef AXI_RD_ADDR_WIDTH
`define AXI_RD_ADDR_WIDTH 32
`endif
`ifndef RD_LEN_WIDTH
`define RD_LEN_WIDTH 16
`endif

module cnn_layer_accel_sys_mem_rd_arb #(
    parameter int C_NUM_RD_ID = `MAX_FAS_RD_ID,
    parameter int C_ADDR_WTH  = `AXI_RD_ADDR_WIDTH,
    parameter int C_LEN_WTH   = `RD_LEN_WIDTH
) (
    input  logic                              clk_core,
    input  logic                              rst,
    input  logic [C_NUM_RD_ID-1:0]            sys_mem_read_req,
    input  logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] sys_mem_read_addr,
    input  logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  sys_mem_read_len,
    output logic [C_NUM_RD_ID-1:0]            sys_mem_read_req_ack,
    output logic [C_NUM_RD_ID-1:0]            sys_mem_read_in_prog,
    output logic [C_NUM_RD_ID-1:0]            sys_mem_read_cmpl,
    output logic                              rd_cmd_valid,
    input  logic                              rd_cmd_ready,
    output logic [C_ADDR_WTH-1:0]             rd_cmd_addr,
    output logic [C_LEN_WTH-1:0]              rd_cmd_len,
    input  logic                              rd_data_valid,
    input  logic                              rd_data_last,
    output logic [C_NUM_RD_ID-1:0]            rd_data_sel,
    output logic                              rd_err
);

    localparam int ID_W = (C_NUM_RD_ID > 1) ? $clog2(C_NUM_RD_ID) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, CMPL} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      pick;
    logic                 pick_vld;
    logic [C_LEN_WTH-1:0] pick_len;
    logic [C_LEN_WTH-1:0] beat_cnt;
    logic                 zero_len;
    logic                 final_beat;
    logic                 ack_d;
    logic                 cmpl_d;
    logic [ID_W-1:0]      ack_id;

    function automatic logic [C_NUM_RD_ID-1:0] to_onehot(input logic [ID_W-1:0] id);
        logic [C_NUM_RD_ID-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Round-robin search: first requesting ID at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < C_NUM_RD_ID; i++) begin
            idx = (int'(rr_ptr) + i) % C_NUM_RD_ID;
            if (!pick_vld && sys_mem_read_req[idx]) begin
                pick     = ID_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_len   = sys_mem_read_len[int'(pick)*C_LEN_WTH +: C_LEN_WTH];
    assign final_beat = (beat_cnt == (rd_cmd_len - 1'b1));
    // In IDLE the winner register is not loaded yet, so a zero-length ack uses the live pick.
    assign ack_id     = (state == IDLE) ? pick : winner;

    // Next-state logic plus the single-cycle ack/cmpl strobes that feed the output registers.
    always_comb begin
        state_nxt = state;
        ack_d     = 1'b0;
        cmpl_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    if (pick_len == '0) begin
                        state_nxt = CMPL;
                        ack_d     = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (rd_cmd_valid && rd_cmd_ready) begin
                    state_nxt = XFER;
                    ack_d     = 1'b1;
                end
            end
            XFER: begin
                if (rd_data_valid && final_beat) begin
                    state_nxt = CMPL;
                    cmpl_d    = 1'b1;
                end
            end
            CMPL: begin
                state_nxt = IDLE;
                // Zero-length transfers complete one cycle after their ack.
                cmpl_d    = zero_len;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, latched request, beat counter, round-robin pointer and error flag.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            state       <= IDLE;
            winner      <= '0;
            zero_len    <= 1'b0;
            rd_cmd_addr <= '0;
            rd_cmd_len  <= '0;
            beat_cnt    <= '0;
            rr_ptr      <= '0;
            rd_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                winner      <= pick;
                zero_len    <= (pick_len == '0);
                rd_cmd_addr <= sys_mem_read_addr[int'(pick)*C_ADDR_WTH +: C_ADDR_WTH];
                rd_cmd_len  <= pick_len;
            end
            if (state != XFER) begin
                beat_cnt <= '0;
            end else if (rd_data_valid) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == CMPL) begin
                if (int'(winner) == C_NUM_RD_ID - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= winner + 1'b1;
                end
            end
            // Protocol checks only flag; the count-based completion is unaffected.
            if (rd_data_valid) begin
                if (state != XFER) begin
                    rd_err <= 1'b1;
                end else if (rd_data_last != final_beat) begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

    // Registered per-ID handshake outputs and the command valid.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            rd_cmd_valid         <= 1'b0;
            sys_mem_read_req_ack <= '0;
            sys_mem_read_in_prog <= '0;
            sys_mem_read_cmpl    <= '0;
            rd_data_sel          <= '0;
        end else begin
            rd_cmd_valid         <= (state_nxt == ISSUE);
            sys_mem_read_req_ack <= ack_d ? to_onehot(ack_id) : '0;
            sys_mem_read_cmpl    <= cmpl_d ? to_onehot(winner) : '0;
            rd_data_sel          <= (state_nxt == XFER) ? to_onehot(winner) : '0;
            if (cmpl_d) begin
                sys_mem_read_in_prog <= '0;
            end else if (ack_d) begin
                sys_mem_read_in_prog <= to_onehot(ack_id);
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_sys_mem_rd_arb.sv
// Directed bench for the system-memory read arbiter.
module tb_cnn_layer_accel_sys_mem_rd_arb;

    localparam int N = 4;
    localparam int A = 32;
    localparam int L = 8;

    logic           clk_core = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*A-1:0] addr_bus;
    logic [N*L-1:0] len_bus;
    logic [N-1:0]   ack;
    logic [N-1:0]   in_prog;
    logic [N-1:0]   cmpl;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [A-1:0]   cmd_addr;
    logic [L-1:0]   cmd_len;
    logic           dvalid;
    logic           dlast;
    logic [N-1:0]   sel;
    logic           err;

    int vec = 0;
    int miscmp = 0;

    cnn_layer_accel_sys_mem_rd_arb #(
        .C_NUM_RD_ID(N), .C_ADDR_WTH(A), .C_LEN_WTH(L)
    ) dut (
        .clk_core            (clk_core),
        .rst                 (rst),
        .sys_mem_read_req    (req),
        .sys_mem_read_addr   (addr_bus),
        .sys_mem_read_len    (len_bus),
        .sys_mem_read_req_ack(ack),
        .sys_mem_read_in_prog(in_prog),
        .sys_mem_read_cmpl   (cmpl),
        .rd_cmd_valid        (cmd_valid),
        .rd_cmd_ready        (cmd_ready),
        .rd_cmd_addr         (cmd_addr),
        .rd_cmd_len          (cmd_len),
        .rd_data_valid       (dvalid),
        .rd_data_last        (dlast),
        .rd_data_sel         (sel),
        .rd_err              (err)
    );

    always #5 clk_core = ~clk_core;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic set_req(input int id, input logic [A-1:0] a, input logic [L-1:0] l);
        addr_bus[id*A +: A] = a;
        len_bus[id*L +: L]  = l;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec++;
        if ({cmd_valid, ack, in_prog, cmpl, sel, err} !== '0 || cmd_addr !== '0 || cmd_len !== '0) begin
            miscmp++;
            $display("FAIL reset_outputs: got valid=%b ack=%b prog=%b cmpl=%b sel=%b err=%b addr=%h len=%h expected all zero",
                     cmd_valid, ack, in_prog, cmpl, sel, err, cmd_addr, cmd_len);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        cmd_ready = 1'b1;
        set_req(2, 32'h1000, 8'd4);
        req = 4'b0100;
        tick();
        vec++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 32'h1000 || cmd_len !== 8'd4 || ack !== 4'b0000) begin
            miscmp++;
            $display("FAIL single_cmd: got valid=%b addr=%h len=%0d ack=%b expected 1 1000 4 0000", cmd_valid, cmd_addr, cmd_len, ack);
        end
        tick();
        vec++;
        if (ack !== 4'b0100 || in_prog !== 4'b0100 || sel !== 4'b0100 || cmd_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL single_ack: got ack=%b prog=%b sel=%b valid=%b expected 0100 0100 0100 0", ack, in_prog, sel, cmd_valid);
        end
        req = '0;
        for (int b = 1; b <= 4; b++) begin
            dvalid = 1'b1;
            dlast  = (b == 4);
            tick();
            if (b < 4) begin
                vec++;
                if (cmpl !== 4'b0000 || sel !== 4'b0100 || ack !== 4'b0000 || in_prog !== 4'b0100) begin
                    miscmp++;
                    $display("FAIL single_beat%0d: got cmpl=%b sel=%b ack=%b prog=%b expected 0000 0100 0000 0100", b, cmpl, sel, ack, in_prog);
                end
            end
        end
        dvalid = 1'b0;
        dlast  = 1'b0;
        vec++;
        if (cmpl !== 4'b0100 || in_prog !== 4'b0000 || sel !== 4'b0000 || err !== 1'b0) begin
            miscmp++;
            $display("FAIL single_cmpl: got cmpl=%b prog=%b sel=%b err=%b expected 0100 0000 0000 0", cmpl, in_prog, sel, err);
        end
        tick();
        vec++;
        if (cmpl !== 4'b0000) begin
            miscmp++;
            $display("FAIL single_cmpl_pulse: got cmpl=%b expected 0000", cmpl);
        end
    endtask

    task automatic test_backpressure();
        cmd_ready = 1'b0;
        set_req(0, 32'h2000, 8'd2);
        req = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            vec++;
            if (cmd_valid !== 1'b1 || cmd_addr !== 32'h2000 || cmd_len !== 8'd2 || ack !== 4'b0000) begin
                miscmp++;
                $display("FAIL bp_hold%0d: got valid=%b addr=%h len=%0d ack=%b expected 1 2000 2 0000", k, cmd_valid, cmd_addr, cmd_len, ack);
            end
            if (k < 4) tick();
        end
        cmd_ready = 1'b1;
        tick();
        vec++;
        if (ack !== 4'b0001 || cmd_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL bp_ack: got ack=%b valid=%b expected 0001 0", ack, cmd_valid);
        end
        req = '0;
        dvalid = 1'b1;
        dlast  = 1'b0;
        tick();
        dlast = 1'b1;
        tick();
        dvalid = 1'b0;
        dlast  = 1'b0;
        vec++;
        if (cmpl !== 4'b0001 || err !== 1'b0) begin
            miscmp++;
            $display("FAIL bp_cmpl: got cmpl=%b err=%b expected 0001 0", cmpl, err);
        end
        tick();
    endtask

    task automatic test_zero_len();
        set_req(1, 32'h5000, 8'd0);
        req = 4'b0010;
        tick();
        vec++;
        if (ack !== 4'b0010 || in_prog !== 4'b0010 || cmd_valid !== 1'b0 || cmpl !== 4'b0000) begin
            miscmp++;
            $display("FAIL zlen_ack: got ack=%b prog=%b valid=%b cmpl=%b expected 0010 0010 0 0000", ack, in_prog, cmd_valid, cmpl);
        end
        req = '0;
        tick();
        vec++;
        if (cmpl !== 4'b0010 || ack !== 4'b0000 || in_prog !== 4'b0000 || cmd_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL zlen_cmpl: got cmpl=%b ack=%b prog=%b valid=%b expected 0010 0000 0000 0", cmpl, ack, in_prog, cmd_valid);
        end
        tick();
        vec++;
        if (cmpl !== 4'b0000 || cmd_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL zlen_after: got cmpl=%b valid=%b expected 0000 0", cmpl, cmd_valid);
        end
    endtask

    task automatic test_errors();
        set_req(3, 32'h4000, 8'd4);
        req = 4'b1000;
        tick();
        tick();
        req = '0;
        for (int b = 1; b <= 4; b++) begin
            dvalid = 1'b1;
            dlast  = (b == 2) || (b == 4);
            tick();
            if (b == 1 || b == 2) begin
                vec++;
                if (err !== (b == 2)) begin
                    miscmp++;
                    $display("FAIL err_early_beat%0d: got err=%b expected %b", b, err, (b == 2));
                end
            end
        end
        dvalid = 1'b0;
        dlast  = 1'b0;
        vec++;
        if (cmpl !== 4'b1000 || err !== 1'b1) begin
            miscmp++;
            $display("FAIL err_early_cmpl: got cmpl=%b err=%b expected 1000 1", cmpl, err);
        end
        tick();
        tick();
        vec++;
        if (err !== 1'b1) begin
            miscmp++;
            $display("FAIL err_sticky: got err=%b expected 1", err);
        end
        pulse_reset();
        vec++;
        if (err !== 1'b0) begin
            miscmp++;
            $display("FAIL err_clear: got err=%b expected 0", err);
        end
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        vec++;
        if (err !== 1'b1) begin
            miscmp++;
            $display("FAIL err_stray: got err=%b expected 1", err);
        end
        pulse_reset();
        set_req(0, 32'h6000, 8'd2);
        req = 4'b0001;
        tick();
        tick();
        req = '0;
        dvalid = 1'b1;
        dlast  = 1'b0;
        tick();
        vec++;
        if (err !== 1'b0) begin
            miscmp++;
            $display("FAIL err_nolast_beat1: got err=%b expected 0", err);
        end
        tick();
        dvalid = 1'b0;
        vec++;
        if (err !== 1'b1 || cmpl !== 4'b0001) begin
            miscmp++;
            $display("FAIL err_nolast: got err=%b cmpl=%b expected 1 0001", err, cmpl);
        end
        tick();
        pulse_reset();
    endtask

    task automatic test_contention();
        int order[$];
        int exp_order[4];
        bit re_req;
        exp_order = '{0, 1, 3, 0};
        re_req = 1'b0;
        pulse_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'h100 * i, 8'd1);
        req = 4'b1011;
        for (int c = 0; c < 200 && !(order.size() == 4 && cmpl == '0 && in_prog == '0 && req == '0); c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    order.push_back(i);
                    req[i] = 1'b0;
                end
            end
            if (cmpl[0] && !re_req) begin
                re_req = 1'b1;
                req[0] = 1'b1;
            end
            dvalid = (sel != '0);
            dlast  = (sel != '0);
        end
        dvalid = 1'b0;
        dlast  = 1'b0;
        vec++;
        if (order.size() != 4) begin
            miscmp++;
            $display("FAIL rr_count: got %0d grants expected 4", order.size());
        end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (k >= order.size()) begin
                miscmp++;
                $display("FAIL rr_grant%0d: got none expected %0d", k, exp_order[k]);
            end else if (order[k] != exp_order[k]) begin
                miscmp++;
                $display("FAIL rr_grant%0d: got %0d expected %0d", k, order[k], exp_order[k]);
            end
        end
        vec++;
        if (err !== 1'b0) begin
            miscmp++;
            $display("FAIL rr_err: got err=%b expected 0", err);
        end
    endtask

    task automatic test_mid_reset();
        cmd_ready = 1'b1;
        set_req(0, 32'h3000, 8'd8);
        req = 4'b0001;
        tick();
        tick();
        req = '0;
        dvalid = 1'b1;
        tick();
        tick();
        dvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if ({cmd_valid, ack, in_prog, cmpl, sel, err} !== '0 || cmd_addr !== '0 || cmd_len !== '0) begin
            miscmp++;
            $display("FAIL midrst_outputs: got valid=%b ack=%b prog=%b cmpl=%b sel=%b err=%b addr=%h len=%h expected all zero",
                     cmd_valid, ack, in_prog, cmpl, sel, err, cmd_addr, cmd_len);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vec++;
            if (cmpl !== 4'b0000 || sel !== 4'b0000) begin
                miscmp++;
                $display("FAIL midrst_quiet%0d: got cmpl=%b sel=%b expected 0000 0000", k, cmpl, sel);
            end
        end
        set_req(1, 32'h7000, 8'd1);
        req = 4'b0010;
        tick();
        vec++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 32'h7000 || cmd_len !== 8'd1) begin
            miscmp++;
            $display("FAIL midrst_next_cmd: got valid=%b addr=%h len=%0d expected 1 7000 1", cmd_valid, cmd_addr, cmd_len);
        end
        tick();
        vec++;
        if (ack !== 4'b0010) begin
            miscmp++;
            $display("FAIL midrst_next_ack: got ack=%b expected 0010", ack);
        end
        req = '0;
        dvalid = 1'b1;
        dlast  = 1'b1;
        tick();
        dvalid = 1'b0;
        dlast  = 1'b0;
        vec++;
        if (cmpl !== 4'b0010 || err !== 1'b0) begin
            miscmp++;
            $display("FAIL midrst_next_cmpl: got cmpl=%b err=%b expected 0010 0", cmpl, err);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        addr_bus  = '0;
        len_bus   = '0;
        cmd_ready = 1'b0;
        dvalid    = 1'b0;
        dlast     = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_zero_len();
        test_errors();
        test_contention();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
